// File: rtl/vga_frame_adapter.sv
// vga_frame_adapter: 160x120 3-bit framebuffer scanned out as 640x480@60 VGA.
// Define VGA_ADAPTER_FB_CLEAR_EN to zero the framebuffer after every reset.
module vga_frame_adapter #(
    parameter int BITS_PER_COLOUR_CHANNEL = 1,
    parameter int FB_WIDTH                = 160,
    parameter int FB_HEIGHT               = 120
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] colour,
    input  logic [7:0]                           x,
    input  logic [6:0]                           y,
    input  logic                                 plot,
    output logic                                 ready,
    output logic [9:0]                           VGA_R,
    output logic [9:0]                           VGA_G,
    output logic [9:0]                           VGA_B,
    output logic                                 VGA_HS,
    output logic                                 VGA_VS,
    output logic                                 VGA_BLANK_N,
    output logic                                 VGA_SYNC_N,
    output logic                                 VGA_CLK
);

    localparam int CW       = 3 * BITS_PER_COLOUR_CHANNEL;
    localparam int BPC      = BITS_PER_COLOUR_CHANNEL;
    localparam int FB_WORDS = FB_WIDTH * FB_HEIGHT;

    localparam logic [7:0] FB_W = 8'(FB_WIDTH);
    localparam logic [6:0] FB_H = 7'(FB_HEIGHT);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_MAX        = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_MAX        = 10'd524;

    // y*160 + x built from shifts so no multiplier is needed
    function automatic logic [14:0] pix_addr(input logic [6:0] row,
                                             input logic [7:0] col);
        logic [14:0] r15;
        r15 = {8'b0, row};
        return (r15 << 7) + (r15 << 5) + {7'b0, col};
    endfunction

    logic          toggle;
    logic          pix_en;
    logic [9:0]    h;
    logic [9:0]    v;
    logic          vis;
    logic          hs_c;
    logic          vs_c;
    logic [14:0]   rd_addr;
    logic [CW-1:0] rd_data;
    logic          hs_d1;
    logic          vs_d1;
    logic          vis_d1;
    logic          wr_ok;
    logic          fb_we;
    logic [14:0]   fb_waddr;
    logic [CW-1:0] fb_wdata;
    logic [CW-1:0] fb_mem [FB_WORDS];

    // Divide the system clock by two; the pixel advances when toggle is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) toggle <= 1'b0;
        else       toggle <= ~toggle;
    end

    assign pix_en     = toggle;
    assign VGA_CLK    = toggle;
    assign VGA_SYNC_N = 1'b0;

    // Raster position: h wraps each line, v steps when h wraps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h == H_MAX) begin
                h <= '0;
                v <= (v == V_MAX) ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Timing decode and scaled read address for the current raster position
    always_comb begin
        vis     = (h < H_VISIBLE) && (v < V_VISIBLE);
        hs_c    = !((h >= H_SYNC_START) && (h < H_SYNC_END));
        vs_c    = !((v >= V_SYNC_START) && (v < V_SYNC_END));
        rd_addr = vis ? pix_addr(v[8:2], h[9:2]) : '0;
    end

    assign wr_ok = plot && ready && (x < FB_W) && (y < FB_H);

`ifdef VGA_ADAPTER_FB_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} clr_state_t;

    localparam logic [14:0] LAST_ADDR = 15'(FB_WORDS - 1);

    clr_state_t  state;
    clr_state_t  state_nxt;
    logic [14:0] clr_addr;
    logic        clr_we;

    // Sweep state register; reset always restarts the clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_CLEAR;
        else       state <= state_nxt;
    end

    // Leave the sweep once the last word is being written
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_addr == LAST_ADDR) state_nxt = ST_RUN;
    end

    // Sweep address, one word per clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  clr_addr <= '0;
        else if (state == ST_CLEAR) clr_addr <= clr_addr + 15'd1;
    end

    // Sweep owns the write port; game writes only once it has finished
    always_comb begin
        ready  = 1'b0;
        clr_we = 1'b0;
        unique case (state)
            ST_CLEAR: clr_we = 1'b1;
            ST_RUN:   ready  = 1'b1;
        endcase
    end

    assign fb_we    = clr_we | wr_ok;
    assign fb_waddr = clr_we ? clr_addr : pix_addr(y, x);
    assign fb_wdata = clr_we ? '0 : colour;
`else
    assign ready    = 1'b1;
    assign fb_we    = wr_ok;
    assign fb_waddr = pix_addr(y, x);
    assign fb_wdata = colour;
`endif

    // Simple dual-port RAM; read-first on a same-address collision
    always_ff @(posedge clock) begin
        if (fb_we)  fb_mem[fb_waddr] <= fb_wdata;
        if (pix_en) rd_data <= fb_mem[rd_addr];
    end

    // First pixel stage: delay sync and blank alongside the RAM read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
            vis_d1 <= 1'b0;
        end else if (pix_en) begin
            hs_d1  <= hs_c;
            vs_d1  <= vs_c;
            vis_d1 <= vis;
        end
    end

    // Second pixel stage: registered pins, colour replicated, black in blanking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= hs_d1;
            VGA_VS      <= vs_d1;
            VGA_BLANK_N <= vis_d1;
            VGA_R       <= vis_d1 ? {10{rd_data[CW-1]}} : '0;
            VGA_G       <= vis_d1 ? {10{rd_data[2*BPC-1]}} : '0;
            VGA_B       <= vis_d1 ? {10{rd_data[BPC-1]}} : '0;
        end
    end

endmodule

// File: tb/tb_vga_frame_adapter.sv
// tb_vga_frame_adapter: directed writes, mid-line reset, then a scoreboarded
// scan of the first 24 lines against a pixel-level reference model.
module tb_vga_frame_adapter;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pins_t;

`ifdef VGA_ADAPTER_FB_CLEAR_EN
    localparam int   READY_LAT = 19200;
    localparam logic READY_RST = 1'b0;
`else
    localparam int   READY_LAT = 0;
    localparam logic READY_RST = 1'b1;
`endif

    localparam int    SCAN_CLKS = 2 * 24 * 800 + 8;
    localparam pins_t RST_PINS  = '{hs: 1'b1, vs: 1'b1, bl: 1'b0,
                                    r: 10'h0, g: 10'h0, b: 10'h0};

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic       ready;
    logic [9:0] VGA_R;
    logic [9:0] VGA_G;
    logic [9:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] fb_m [19200];
    pins_t      sb_q [$];

    vga_frame_adapter dut (
        .clock       (clock),
        .reset       (reset),
        .colour      (colour),
        .x           (x),
        .y           (y),
        .plot        (plot),
        .ready       (ready),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pins_t pins_now();
        return {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B};
    endfunction

    // Expected pins for linear pixel index p counted from (0,0)
    function automatic pins_t expect_pix(input int p);
        int         hh;
        int         vv;
        logic       on;
        logic [2:0] c;
        pins_t      e;
        hh = p % 800;
        vv = (p / 800) % 525;
        on = (hh < 640) && (vv < 480);
        c  = 3'b000;
        if (on) c = fb_m[(vv / 4) * 160 + hh / 4];
        e.hs = !(hh >= 656 && hh < 752);
        e.vs = !(vv >= 490 && vv < 492);
        e.bl = on;
        e.r  = c[2] ? 10'h3FF : 10'h000;
        e.g  = c[1] ? 10'h3FF : 10'h000;
        e.b  = c[0] ? 10'h3FF : 10'h000;
        return e;
    endfunction

    // One plot cycle, driven from a falling edge
    task automatic write_px(input int px, input int py, input logic [2:0] c);
        x      = 8'(px);
        y      = 7'(py);
        colour = c;
        plot   = 1'b1;
        @(negedge clock);
        plot = 1'b0;
        if (px < 160 && py < 120) fb_m[py * 160 + px] = c;
    endtask

    initial begin
        int    n;
        int    low_run;
        int    fall_k;
        pins_t exp_p;
        reset  = 1'b1;
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        for (int i = 0; i < 19200; i++) fb_m[i] = 3'b000;

        // Power-on reset state
        repeat (3) @(negedge clock);
        check("rst_pins", 64'(pins_now()), 64'(RST_PINS));
        check("rst_vga_clk", 64'(VGA_CLK), 64'(0));
        check("rst_sync_n", 64'(VGA_SYNC_N), 64'(0));
        check("rst_ready", 64'(ready), 64'(READY_RST));
        reset = 1'b0;

        // Wait for writes to be accepted
        n = 0;
        while (!ready && n < 25000) begin
            @(negedge clock);
            n++;
        end
        check("ready_latency", 64'(n), 64'(READY_LAT));

        // In-range pixels, including the corners of the scanned rows
        write_px(0, 0, 3'b101);
        write_px(159, 5, 3'b011);
        write_px(159, 0, 3'b100);
        write_px(1, 1, 3'b110);
        write_px(80, 3, 3'b010);
        write_px(10, 5, 3'b111);
        // Out of range: would alias onto visible pixels if not filtered
        write_px(160, 0, 3'b111);
        write_px(200, 1, 3'b111);
        write_px(255, 0, 3'b111);
        write_px(0, 120, 3'b111);
        write_px(100, 127, 3'b111);

        // Reset in the middle of a line
        repeat (437) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_pins", 64'(pins_now()), 64'(RST_PINS));
        check("midrst_vga_clk", 64'(VGA_CLK), 64'(0));
`ifdef VGA_ADAPTER_FB_CLEAR_EN
        for (int i = 0; i < 19200; i++) fb_m[i] = 3'b000;
`endif
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Scan: expectation pushed as the raster reaches a pixel, popped
        // two pixel clocks later when the pins present it
        sb_q.push_back(expect_pix(0));
        low_run = 0;
        fall_k  = -1;
        for (int k = 1; k <= SCAN_CLKS; k++) begin
            @(negedge clock);
`ifdef VGA_ADAPTER_FB_CLEAR_EN
            if (k == 10) begin
                x      = 8'd10;
                y      = 7'd5;
                colour = 3'b111;
                plot   = 1'b1;
            end
            if (k == 11) plot = 1'b0;
            if (k == 19199) check("ready_sweep_low", 64'(ready), 64'(0));
            if (k == 19200) check("ready_sweep_done", 64'(ready), 64'(1));
`else
            if (k == 100) check("ready_tied", 64'(ready), 64'(1));
`endif
            check("vga_clk", 64'(VGA_CLK), 64'(k % 2));
            if (k % 2 == 0) begin
                check($sformatf("sync_n k=%0d", k), 64'(VGA_SYNC_N), 64'(0));
                sb_q.push_back(expect_pix(k / 2));
                if (sb_q.size() > 2) begin
                    exp_p = sb_q.pop_front();
                    check($sformatf("pix p=%0d", k / 2 - 2),
                          64'(pins_now()), 64'(exp_p));
                end
            end
            if (VGA_HS === 1'b0) begin
                if (low_run == 0) begin
                    if (fall_k >= 0)
                        check("hs_period", 64'(k - fall_k), 64'(1600));
                    else
                        check("hs_first_fall", 64'(k), 64'(1316));
                    fall_k = k;
                end
                low_run++;
            end else begin
                if (low_run > 0) check("hs_low_clks", 64'(low_run), 64'(192));
                low_run = 0;
            end
        end
        check("hs_seen", 64'(fall_k > 0), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
